// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory wait, multi-cycle EX ops, branch redirect, load-use.
// Optional status counters (stall_cycles, flush_count) are built when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int DIV_CYCLES = 34,
  parameter int REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_multi,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_load,
  output logic              if_id_load,
  output logic              if_id_clear,
  output logic              id_ex_load,
  output logic              id_ex_clear,
  output logic              ex_mem_load,
  output logic              ex_mem_clear,
  output logic              mem_wb_load,
  output logic              mem_wb_clear
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 2);

  typedef enum logic {RUN = 1'b0, MULTI = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_wait;
  logic load_use;
  logic multi_stall;

  assign mem_wait = mem_req & ~mem_ready;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign multi_stall = (state_q == RUN) ? ex_multi : (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The countdown keeps running through a memory wait; only the release waits for mem_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_multi && !mem_wait) begin
          state_d = MULTI;
          cnt_d   = CNT_INIT;
        end
      end
      MULTI: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!mem_wait) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_load   = 1'b1;
    id_ex_clear  = 1'b0;
    ex_mem_load  = 1'b1;
    ex_mem_clear = 1'b0;
    mem_wb_load  = 1'b1;
    mem_wb_clear = 1'b0;
    if (!rst_n) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (mem_wait) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_load  = 1'b0;
      mem_wb_clear = 1'b1;
    end else if (multi_stall) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      ex_mem_clear = 1'b1;
    end else if ((state_q == RUN) && ex_branch_taken) begin
      // Redirect squashes the ID instruction, so any load-use it had is moot.
      if_id_load  = 1'b0;
      if_id_clear = 1'b1;
      id_ex_load  = 1'b0;
      id_ex_clear = 1'b1;
    end else if ((state_q == RUN) && load_use) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      id_ex_clear = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic        branch_act;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  assign branch_act = rst_n && !mem_wait && !multi_stall &&
                      (state_q == RUN) && ex_branch_taken;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'b0, ~pc_load};
    flush_count_d  = flush_count_q + {31'b0, branch_act};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (DIV_CYCLES=4 and 2) share stimulus and are
// checked against an occupancy-based reference model; stats counters are checked when HAZARD_STATS_EN is set.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       mul;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct {
    logic [8:0]  o4;
    logic [8:0]  o2;
    logic [31:0] s4;
    logic [31:0] f4;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       ex_mem_read = 1'b0, ex_multi = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b0;

  logic pc_load4, if_id_load4, if_id_clear4, id_ex_load4, id_ex_clear4;
  logic ex_mem_load4, ex_mem_clear4, mem_wb_load4, mem_wb_clear4;
  logic pc_load2, if_id_load2, if_id_clear2, id_ex_load2, id_ex_clear2;
  logic ex_mem_load2, ex_mem_clear2, mem_wb_load2, mem_wb_clear2;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles4, flush_count4, stall_cycles2, flush_count2;
`endif

  exp_t exp_q[$];
  int   num_checks = 0;
  int   num_errors = 0;
  int   cycle_no = 0;

  // Model state: cycles the current multi-cycle op has spent in EX (0 = none).
  int          age4 = 0;
  int          age2 = 0;
  logic [31:0] stall_m = '0;
  logic [31:0] flush_m = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_CYCLES(4), .REG_AW(5)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multi(ex_multi),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load4), .if_id_load(if_id_load4), .if_id_clear(if_id_clear4),
    .id_ex_load(id_ex_load4), .id_ex_clear(id_ex_clear4),
    .ex_mem_load(ex_mem_load4), .ex_mem_clear(ex_mem_clear4),
    .mem_wb_load(mem_wb_load4), .mem_wb_clear(mem_wb_clear4)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles4), .flush_count(flush_count4)
`endif
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(2), .REG_AW(5)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multi(ex_multi),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load2), .if_id_load(if_id_load2), .if_id_clear(if_id_clear2),
    .id_ex_load(id_ex_load2), .id_ex_clear(id_ex_clear2),
    .ex_mem_load(ex_mem_load2), .ex_mem_clear(ex_mem_clear2),
    .mem_wb_load(mem_wb_load2), .mem_wb_clear(mem_wb_clear2)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles2), .flush_count(flush_count2)
`endif
  );

  // Expected outputs packed as {pc, if_id_ld, if_id_clr, id_ex_ld, id_ex_clr, ex_mem_ld, ex_mem_clr, mem_wb_ld, mem_wb_clr}.
  function automatic logic [8:0] model_out(int age, int div);
    logic [8:0] o;
    logic       mw, lu;
    int         cur;
    if (!rst_n) return 9'b0;
    mw  = mem_req && !mem_ready;
    lu  = ex_mem_read && (ex_rd != 5'd0) &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    cur = (age > 0) ? age : (ex_multi ? 1 : 0);
    o   = 9'b1_10_10_10_10;
    if (mw)                       o = 9'b0_00_00_00_01;
    else if (cur > 0 && cur < div) o = 9'b0_00_00_01_10;
    else if (age == 0 && ex_branch_taken) o = 9'b1_01_01_10_10;
    else if (age == 0 && lu)      o = 9'b0_00_01_10_10;
    return o;
  endfunction

  function automatic int model_next(int age, int div);
    logic mw;
    int   cur;
    mw  = mem_req && !mem_ready;
    cur = (age > 0) ? age : (ex_multi ? 1 : 0);
    if (cur == 0) return 0;
    if (age == 0 && mw) return 0;
    if (cur >= div) return mw ? div : 0;
    return cur + 1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    num_checks++;
    if (got !== want) begin
      num_errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cycle_no, got, want);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    cycle_no++;
    rst_n = s.rst_n; id_rs1 = s.rs1; id_rs2 = s.rs2; id_use_rs1 = s.u1; id_use_rs2 = s.u2;
    ex_rd = s.rd; ex_mem_read = s.mr; ex_multi = s.mul; ex_branch_taken = s.br;
    mem_req = s.req; mem_ready = s.rdy;
    if (!rst_n) begin
      stall_m = '0;
      flush_m = '0;
    end
    e.o4 = model_out(age4, 4);
    e.o2 = model_out(age2, 2);
    e.s4 = stall_m;
    e.f4 = flush_m;
    exp_q.push_back(e);
    if (!rst_n) begin
      age4 = 0;
      age2 = 0;
    end else begin
      age4 = model_next(age4, 4);
      age2 = model_next(age2, 2);
      if (!e.o4[8]) stall_m = stall_m + 32'd1;
      if (e.o4[6])  flush_m = flush_m + 32'd1;
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set; compare it against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("outs_div4", {23'b0, pc_load4, if_id_load4, if_id_clear4, id_ex_load4, id_ex_clear4,
                  ex_mem_load4, ex_mem_clear4, mem_wb_load4, mem_wb_clear4}, {23'b0, e.o4});
      checkOutput("outs_div2", {23'b0, pc_load2, if_id_load2, if_id_clear2, id_ex_load2, id_ex_clear2,
                  ex_mem_load2, ex_mem_clear2, mem_wb_load2, mem_wb_clear2}, {23'b0, e.o2});
`ifdef HAZARD_STATS_EN
      checkOutput("stall_cycles", stall_cycles4, e.s4);
      checkOutput("flush_count", flush_count4, e.f4);
`endif
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cycle_no);
    num_errors++;
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

  initial begin
    stim_t s, lu;
    s = idle(); s.rst_n = 1'b0;
    repeat (2) applyStimulus(s);
    repeat (2) applyStimulus(idle());

    lu = idle(); lu.mr = 1'b1; lu.rd = 5'd5; lu.rs1 = 5'd5; lu.u1 = 1'b1;
    applyStimulus(lu);
    repeat (2) applyStimulus(idle());
    s = lu; s.rd = 5'd0; s.rs1 = 5'd0;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.mul = 1'b1;
    repeat (4) applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = lu; s.br = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());

    s = idle(); s.mul = 1'b1;
    repeat (2) applyStimulus(s);
    s.req = 1'b1;
    repeat (3) applyStimulus(s);
    s.rdy = 1'b1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = idle(); s.mul = 1'b1;
    repeat (2) applyStimulus(s);
    s = idle(); s.rst_n = 1'b0; s.mul = 1'b1;
    applyStimulus(s);
    repeat (2) applyStimulus(idle());

    s = idle(); s.br = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(s);
    applyStimulus(idle());

    for (int i = 0; i < 1500; i++) begin
      s.rst_n = ($urandom_range(0, 199) != 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.mr    = ($urandom_range(0, 2) == 0);
      s.mul   = ($urandom_range(0, 11) == 0);
      s.br    = ($urandom_range(0, 5) == 0);
      s.req   = 1'($urandom_range(0, 1));
      s.rdy   = ($urandom_range(0, 2) != 0);
      applyStimulus(s);
    end

    repeat (2) @(negedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
